swbut_conditioner: RTL
======================

# swbut_conditioner

Input conditioner that produces the 16-bit switch/button word consumed by the collatz `swbut` top (`in[15:0]`). It synchronizes raw board switches and buttons and debounces each bit independently. It drives the stable word to the top and emits a one-cycle `press` pulse for the designated button bit. It sits between the board pins and `top.in`, on the same clock as the top.

## Interface
- `WIDTH`, 16: number of switch/button bits.
- `DEBOUNCE_CYCLES`, 1000: consecutive cycles a synchronized bit must differ from its stable value before the stable value flips; must be ≥ 2.
- `BUTTON_BIT`, 15: index of the bit treated as the start button for `press`.
- `REPEAT_CYCLES`, 50000: autorepeat period; used only with `SWBUT_AUTOREPEAT_EN`.

Ports:
- `clk` input 1: the only clock; all logic is on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `raw` input WIDTH: asynchronous pin levels.
- `in_word` output WIDTH: debounced stable word; connects to `top.in`.
- `press` output 1: one-cycle pulse on each qualified press of `BUTTON_BIT`.

## Operation
- Synchronizer: two flops per bit, `s1 <= raw`, `s2 <= s1`.
- Per-bit debounce state:
  - `stable` register (drives `in_word`) plus a counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - Each cycle, per bit:
    - if `s2 == stable`: `cnt <= 0`.
    - else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
    - else `cnt <= cnt + 1`.
  - A mismatch lasting fewer than `DEBOUNCE_CYCLES` cycles resets the counter and leaves `stable` unchanged.
  - Bits are fully independent; simultaneous changes on several bits qualify on the same edge.
- Press detection:
  - `press` is registered and equals `stable[BUTTON_BIT] & ~stable_d`, where `stable_d` is `stable[BUTTON_BIT]` delayed one cycle.
  - Release produces no pulse.
- Reset (`rst_n` low at an edge): `s1`, `s2`, `stable`, `cnt`, `stable_d` and the repeat counter all go to 0.
  - Outputs after reset: `in_word = 0`, `press = 0`.
  - Reset mid-qualification discards partial counts.
  - A button held through reset re-qualifies with full latency and then produces a `press`.

## Timing
- A `raw` change applied before edge 0 is captured in `s1` at edge 0 and appears in `s2` after edge 1.
- `in_word` changes after edge `DEBOUNCE_CYCLES+1`, i.e. latency `DEBOUNCE_CYCLES+2` edges.
- `press` is high for exactly the one cycle following the edge where `stable[BUTTON_BIT]` rises, one edge after the `in_word` change.
- `in_word` is glitch-free: at most one transition per bit per `DEBOUNCE_CYCLES` cycles.

## Configuration
- `SWBUT_AUTOREPEAT_EN` defined:
  - While `stable[BUTTON_BIT]` remains 1, a repeat counter cleared at the initial press emits an extra one-cycle `press` every `REPEAT_CYCLES` cycles.
  - The first repeat comes `REPEAT_CYCLES` cycles after the initial pulse.
  - The counter clears when the bit falls or on reset.
- Undefined: the repeat counter is not built, `REPEAT_CYCLES` is ignored, and there is exactly one pulse per press.

## Test plan
- Reset with `raw = 16'h8001` and `rst_n = 0` for 3 cycles -> `in_word = 0` and `press = 0` during and on the first cycle after reset.
- `DEBOUNCE_CYCLES = 4`, `raw` steps 0 -> `16'h8001` before edge 0 -> `in_word = 16'h8001` after edge 5, single `press` cycle after edge 6.
- `DEBOUNCE_CYCLES = 4`, bit 0 glitch high for 3 cycles then low -> `in_word` stays 0 and `press` never asserts.
- Bit 15 bounces 1,0,1,1,1,1 (`DEBOUNCE_CYCLES = 4`) -> exactly one `in_word` transition and one `press`; release yields no `press`.
- `rst_n` pulsed low at cycle 3 of a 4-cycle qualification -> `in_word` stays 0 until a full 6-edge latency from reset release, then one `press`.
- With `SWBUT_AUTOREPEAT_EN`, `REPEAT_CYCLES = 10`, bit 15 held 40 cycles past qualification -> `press` pulses at +0, +10, +20, +30; without the macro -> only the +0 pulse.

Source files
------------

// File: rtl/swbut_conditioner.sv
// rtl/swbut_conditioner.sv - synchronizer, per-bit debouncer and start-button press pulse
//
// Produces the 16-bit switch/button word for the collatz swbut top.
// Each raw pin goes through a two-flop synchronizer, then an independent
// debouncer that flips its stable value only after DEBOUNCE_CYCLES
// consecutive disagreeing samples. A registered one-cycle press pulse is
// emitted when the stable copy of BUTTON_BIT rises.
//
// Optional feature macro: SWBUT_AUTOREPEAT_EN
//   defined   - while the button stays held, an extra press pulse is emitted
//               every REPEAT_CYCLES cycles after the initial one.
//   undefined - one pulse per press; REPEAT_CYCLES is only range-checked.
//
// Ports:
//   clk      in   1      rising-edge clock, shared with the consumer
//   rst_n    in   1      synchronous active-low reset
//   raw      in   WIDTH  asynchronous pin levels
//   in_word  out  WIDTH  debounced stable word
//   press    out  1      one-cycle pulse per qualified press of BUTTON_BIT

module swbut_conditioner #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int BUTTON_BIT      = 15,
    parameter int REPEAT_CYCLES   = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] in_word,
    output logic             press
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("swbut_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (BUTTON_BIT < 0 || BUTTON_BIT >= WIDTH) begin : g_bad_button
        $error("swbut_conditioner: BUTTON_BIT out of range");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("swbut_conditioner: REPEAT_CYCLES must be at least 1");
    end

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchronizer and debounce state.
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Press detection state.
    logic btn_dly_q;
    logic press_q;
    logic press_d;
    logic rise;

    // Debounce next state: a bit that agrees with its stable value holds
    // its counter at zero; a disagreeing bit counts, and flips the stable
    // value on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_q[BUTTON_BIT] & ~btn_dly_q;

`ifdef SWBUT_AUTOREPEAT_EN
    localparam int               REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
    logic             rep_fire;

    // The repeat counter restarts on the initial press and whenever the
    // button is released, so the first repeat lands REPEAT_CYCLES after
    // the initial pulse.
    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (!stable_q[BUTTON_BIT] || rise) begin
            rep_d = '0;
        end else if (rep_q == REP_LAST) begin
            rep_d    = '0;
            rep_fire = 1'b1;
        end else begin
            rep_d = rep_q + REP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    always_comb begin
        press_d = rise | rep_fire;
    end
`else
    always_comb begin
        press_d = rise;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            btn_dly_q <= 1'b0;
            press_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= raw;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            btn_dly_q <= stable_q[BUTTON_BIT];
            press_q   <= press_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_word = stable_q;
    assign press   = press_q;

endmodule
